// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the 5-stage ARM pipeline control blocks:
// forwarding-select codes, NZCV bit positions and the EXE hazard FSM states.
package arm_pipe_pkg;

  // Operand source selects seen by the EXE operand muxes
  localparam logic [1:0] FWD_SRC_REG = 2'd0;  // value read from the register file
  localparam logic [1:0] FWD_SRC_MEM = 2'd1;  // ALU result sitting in the MEM slot
  localparam logic [1:0] FWD_SRC_WB  = 2'd2;  // write-back value sitting in the WB slot

  // Bit positions inside the NZCV status register
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // EXE hazard sequencer states
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  // A slot produces a register only if it holds a real instruction that writes back
  function automatic logic slot_hit(input logic valid, input logic wb_en, input logic dest_eq);
    return valid & wb_en & dest_eq;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one source register: compares the source
// against the MEM and WB slot destinations and picks the newest producer.
module fwd_select
  import arm_pipe_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          check_en_i,   // source is actually read
  input  logic [AW-1:0] src_i,
  input  logic          mem_valid_i,
  input  logic          mem_wb_en_i,
  input  logic          mem_load_i,
  input  logic [AW-1:0] mem_dest_i,
  input  logic          wb_valid_i,
  input  logic          wb_wb_en_i,
  input  logic [AW-1:0] wb_dest_i,
  output logic [1:0]    sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = check_en_i & slot_hit(mem_valid_i, mem_wb_en_i, mem_dest_i == src_i);
  assign wb_hit  = check_en_i & slot_hit(wb_valid_i, wb_wb_en_i, wb_dest_i == src_i);

  // MEM is newer than WB; a load in MEM has no data yet, so it never forwards
  always_comb begin
    sel_o = FWD_SRC_REG;
    if (mem_hit && !mem_load_i) begin
      sel_o = FWD_SRC_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_SRC_WB;
    end
  end

endmodule

// File: rtl/exe_hazard_controller.sv
// EXE-stage sequencer for the 5-stage ARM pipeline. Shadows the EXE/MEM/WB
// slots, generates forwarding selects, load-use / no-forward stalls, branch
// flush and memory-wait freeze, and owns the NZCV status register.
module exe_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              id_s,
  input  logic              id_branch,
  input  logic [3:0]        exe_status_bits,
  input  logic              mem_busy,
  output logic              freeze,
  output logic              hazard_stall,
  output logic              flush,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic [3:0]        status_reg,
  output logic              c_in
);

  // Full shadow of the instruction currently in EXE
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb_en;
    logic              mem_read;
    logic              s;
    logic              branch;
  } exe_slot_t;

  exe_slot_t exe_q, exe_d;

  // MEM and WB slots keep only what the forwarding compare consumes;
  // the flag-set and branch bits have done their job once they leave EXE.
  logic              mem_valid_q;
  logic              mem_wb_en_q;
  logic              mem_load_q;
  logic [REG_AW-1:0] mem_dest_q;
  logic              wb_valid_q;
  logic              wb_wb_en_q;
  logic [REG_AW-1:0] wb_dest_q;

  logic [3:0] status_q, status_d;
  hz_state_e  state_q, state_d;

  logic exe_hit1, exe_hit2;
  logic mem_hit1, mem_hit2;
  logic stall_raw;
  logic lu_gate;
  logic branch_in_exe;

  logic [REG_AW-1:0] src_arr [2];
  logic              chk_arr [2];
  logic [1:0]        fsel_arr[2];

  // ---------------------------------------------------------------------------
  // Hazard detection against the EXE and MEM slots
  // ---------------------------------------------------------------------------
  assign exe_hit1 = slot_hit(exe_q.valid, exe_q.wb_en, exe_q.dest == id_src1);
  assign exe_hit2 = id_two_src & slot_hit(exe_q.valid, exe_q.wb_en, exe_q.dest == id_src2);
  assign mem_hit1 = slot_hit(mem_valid_q, mem_wb_en_q, mem_dest_q == id_src1);
  assign mem_hit2 = id_two_src & slot_hit(mem_valid_q, mem_wb_en_q, mem_dest_q == id_src2);

  // With forwarding only a load directly ahead forces a wait; without it any
  // in-flight producer in EXE or MEM does.
  assign stall_raw = id_valid & (FWD_EN ? (exe_q.mem_read & (exe_hit1 | exe_hit2))
                                        : (exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2));

  // The cycle after a load-use stall EXE holds the bubble, so a repeat stall
  // is never legitimate with forwarding on. Without forwarding the producer
  // is still in MEM and the second stall cycle is required.
  assign lu_gate = FWD_EN & (state_q == HZ_LU_STALL);

  assign branch_in_exe = exe_q.valid & exe_q.branch;

  // ---------------------------------------------------------------------------
  // Forwarding selects, one comparator per source operand
  // ---------------------------------------------------------------------------
  assign src_arr[0] = id_src1;
  assign src_arr[1] = id_src2;
  assign chk_arr[0] = 1'b1;
  assign chk_arr[1] = id_two_src;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd_sel
    fwd_select #(
      .AW (REG_AW)
    ) u_fwd_select (
      .check_en_i  (chk_arr[gi]),
      .src_i       (src_arr[gi]),
      .mem_valid_i (mem_valid_q),
      .mem_wb_en_i (mem_wb_en_q),
      .mem_load_i  (mem_load_q),
      .mem_dest_i  (mem_dest_q),
      .wb_valid_i  (wb_valid_q),
      .wb_wb_en_i  (wb_wb_en_q),
      .wb_dest_i   (wb_dest_q),
      .sel_o       (fsel_arr[gi])
    );
  end

  assign sel_src1 = FWD_EN ? fsel_arr[0] : FWD_SRC_REG;
  assign sel_src2 = FWD_EN ? fsel_arr[1] : FWD_SRC_REG;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: memory wait dominates, load-use lasts a single edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_busy) begin
          state_d = HZ_MEM_WAIT;
        end else if (hazard_stall) begin
          state_d = HZ_LU_STALL;
        end
      end
      HZ_LU_STALL: begin
        state_d = mem_busy ? HZ_MEM_WAIT : HZ_RUN;
      end
      HZ_MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Outputs: freeze masks everything, flush wins over a stall
  always_comb begin
    freeze       = mem_busy;
    flush        = branch_in_exe & ~mem_busy;
    hazard_stall = stall_raw & ~lu_gate & ~mem_busy & ~branch_in_exe;
  end

  // ---------------------------------------------------------------------------
  // Slot pipeline
  // ---------------------------------------------------------------------------

  // Next EXE occupant: bubble on flush or stall, otherwise the ID instruction
  always_comb begin
    exe_d          = '0;
    if (!flush && !hazard_stall) begin
      exe_d.valid    = id_valid;
      exe_d.dest     = id_dest;
      exe_d.wb_en    = id_wb_en;
      exe_d.mem_read = id_mem_read;
      exe_d.s        = id_s;
      exe_d.branch   = id_branch;
    end
  end

  // Advance all slots together unless the memory side holds the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_wb_en_q <= 1'b0;
      mem_load_q  <= 1'b0;
      mem_dest_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_wb_en_q  <= 1'b0;
      wb_dest_q   <= '0;
    end else if (!freeze) begin
      exe_q       <= exe_d;
      mem_valid_q <= exe_q.valid;
      mem_wb_en_q <= exe_q.wb_en;
      mem_load_q  <= exe_q.mem_read;
      mem_dest_q  <= exe_q.dest;
      wb_valid_q  <= mem_valid_q;
      wb_wb_en_q  <= mem_wb_en_q;
      wb_dest_q   <= mem_dest_q;
    end
  end

  // ---------------------------------------------------------------------------
  // NZCV status register
  // ---------------------------------------------------------------------------

  // Capture the ALU flags only for a real flag-setting instruction in EXE
  always_comb begin
    status_d = status_q;
    if (exe_q.valid && exe_q.s) begin
      status_d[NZCV_N] = exe_status_bits[NZCV_N];
      status_d[NZCV_Z] = exe_status_bits[NZCV_Z];
      status_d[NZCV_C] = exe_status_bits[NZCV_C];
      status_d[NZCV_V] = exe_status_bits[NZCV_V];
    end
  end

  // Status updates on the same edges the slots advance
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else if (!freeze) begin
      status_q <= status_d;
    end
  end

  // Registered carry, so a flag-setter only affects later instructions
  assign status_reg = status_q;
  assign c_in       = status_q[NZCV_C];

endmodule

// File: tb/tb_exe_hazard_controller.sv
// Self-checking bench: one forwarding and one non-forwarding instance share
// the same stimulus; each is compared against its own in-flight-instruction
// reference model every cycle, plus directed absolute checks.
module tb_exe_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_dest, id_src1, id_src2;
  logic       id_two_src, id_wb_en, id_mem_read, id_s, id_branch;
  logic [3:0] st_bits;
  logic       mem_busy;

  // index 0 = forwarding disabled, index 1 = forwarding enabled
  logic [1:0] frz_w, stl_w, fls_w, cin_w;
  logic [1:0] sel1_w [2];
  logic [1:0] sel2_w [2];
  logic [3:0] stat_w [2];

  always #5 clk = ~clk;

  exe_hazard_controller #(.REG_AW(4), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_s(id_s), .id_branch(id_branch), .exe_status_bits(st_bits), .mem_busy(mem_busy),
    .freeze(frz_w[0]), .hazard_stall(stl_w[0]), .flush(fls_w[0]), .sel_src1(sel1_w[0]),
    .sel_src2(sel2_w[0]), .status_reg(stat_w[0]), .c_in(cin_w[0]));

  exe_hazard_controller #(.REG_AW(4), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_src1(id_src1),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_s(id_s), .id_branch(id_branch), .exe_status_bits(st_bits), .mem_busy(mem_busy),
    .freeze(frz_w[1]), .hazard_stall(stl_w[1]), .flush(fls_w[1]), .sel_src1(sel1_w[1]),
    .sel_src2(sel2_w[1]), .status_reg(stat_w[1]), .c_in(cin_w[1]));

  // Reference model: instructions in flight, [0]=EXE, [1]=MEM, [2]=WB
  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       ld;
    logic       s;
    logic       br;
  } ins_t;

  ins_t       flight [2][3];
  logic [3:0] stat_m [2];
  int         n_vec = 0;
  int         n_err = 0;
  bit         last_stall1 = 0;
  bit         last_busy = 0;

  function automatic bit prod(int k, int j, logic [3:0] r);
    return flight[k][j].valid && flight[k][j].wb_en && (flight[k][j].dest == r);
  endfunction

  function automatic logic [1:0] fwd_pick(int k, logic [3:0] r, bit used);
    if (!used || k == 0) return 2'd0;
    if (prod(k, 1, r) && !flight[k][1].ld) return 2'd1;
    if (prod(k, 2, r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit exp_flush(int k);
    return flight[k][0].valid && flight[k][0].br && !mem_busy;
  endfunction

  function automatic bit exp_stall(int k);
    bit reads_exe;
    bit reads_mem;
    bit raw;
    reads_exe = prod(k, 0, id_src1) || (id_two_src && prod(k, 0, id_src2));
    reads_mem = prod(k, 1, id_src1) || (id_two_src && prod(k, 1, id_src2));
    raw = (k == 1) ? (reads_exe && flight[k][0].ld) : (reads_exe || reads_mem);
    return id_valid && raw && !mem_busy && !exp_flush(k);
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input bit v, input logic [3:0] d, input logic [3:0] s1,
                        input logic [3:0] s2, input bit two, input bit wb,
                        input bit ld, input bit s, input bit br);
    id_valid = v; id_dest = d; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_mem_read = ld; id_s = s; id_branch = br;
  endtask

  task automatic nop();
    set_id(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge
  task automatic cycle(input bit do_check);
    bit   fl [2];
    bit   stl[2];
    ins_t nw;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      fl[k]  = exp_flush(k);
      stl[k] = exp_stall(k);
      if (do_check) begin
        check($sformatf("freeze[%0d]", k), 4'(frz_w[k]), 4'(mem_busy));
        check($sformatf("flush[%0d]", k),  4'(fls_w[k]), 4'(fl[k]));
        check($sformatf("stall[%0d]", k),  4'(stl_w[k]), 4'(stl[k]));
        check($sformatf("sel1[%0d]", k),   4'(sel1_w[k]), 4'(fwd_pick(k, id_src1, 1'b1)));
        check($sformatf("sel2[%0d]", k),   4'(sel2_w[k]), 4'(fwd_pick(k, id_src2, id_two_src)));
        check($sformatf("status[%0d]", k), stat_w[k], stat_m[k]);
        check($sformatf("c_in[%0d]", k),   4'(cin_w[k]), 4'(stat_m[k][1]));
      end
    end
    last_stall1 = stl[1];
    last_busy   = mem_busy;
    @(posedge clk);
    nw.valid = id_valid; nw.dest = id_dest; nw.wb_en = id_wb_en;
    nw.ld = id_mem_read; nw.s = id_s; nw.br = id_branch;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) flight[k][j] = '0;
        stat_m[k] = 4'd0;
      end else if (!mem_busy) begin
        if (flight[k][0].valid && flight[k][0].s) stat_m[k] = st_bits;
        flight[k][2] = flight[k][1];
        flight[k][1] = flight[k][0];
        flight[k][0] = (fl[k] || stl[k]) ? '0 : nw;
      end
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) flight[k][j] = '0;
      stat_m[k] = 4'd0;
    end
    rst = 1'b1; mem_busy = 1'b0; st_bits = 4'd0; nop();
    #1;
    cycle(0);
    cycle(1);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_status[%0d]", k), stat_w[k], 4'd0);
      check($sformatf("rst_cin[%0d]", k), 4'(cin_w[k]), 4'd0);
      check($sformatf("rst_stall[%0d]", k), 4'(stl_w[k]), 4'd0);
      check($sformatf("rst_flush[%0d]", k), 4'(fls_w[k]), 4'd0);
    end

    // ADD R1 ; ADD R2,R1,R3 ; ADD R6,R1
    set_id(1, 4'd1, 4'd2, 4'd3, 1, 1, 0, 0, 0); cycle(1);
    set_id(1, 4'd2, 4'd1, 4'd3, 1, 1, 0, 0, 0); cycle(1);
    set_id(1, 4'd6, 4'd1, 4'd0, 0, 1, 0, 0, 0); cycle(1);
    set_id(1, 4'd7, 4'd1, 4'd2, 1, 1, 0, 0, 0); cycle(1);
    nop(); cycle(1); cycle(1); cycle(1);

    // LDR R4 ; SUB R5,R4,#1 held in ID while stalled
    set_id(1, 4'd4, 4'd0, 4'd0, 0, 1, 1, 0, 0); cycle(1);
    set_id(1, 4'd5, 4'd4, 4'd0, 0, 1, 0, 0, 0); #1;
    check("lu_stall_fwd", 4'(stl_w[1]), 4'd1);
    check("lu_stall_nofwd", 4'(stl_w[0]), 4'd1);
    cycle(1);
    check("lu_second_fwd", 4'(stl_w[1]), 4'd0);
    check("lu_second_nofwd", 4'(stl_w[0]), 4'd1);
    cycle(1);
    check("lu_third_nofwd", 4'(stl_w[0]), 4'd0);
    check("lu_wb_sel_fwd", 4'(sel1_w[1]), 4'd2);
    nop(); cycle(1); cycle(1); cycle(1);

    // Taken B then ADD R7 (flag-setting) in its shadow
    set_id(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1); cycle(1);
    set_id(1, 4'd7, 4'd1, 4'd2, 1, 1, 0, 1, 0); st_bits = 4'b1111; #1;
    check("flush_fwd", 4'(fls_w[1]), 4'd1);
    check("flush_nofwd", 4'(fls_w[0]), 4'd1);
    cycle(1);
    nop(); cycle(1);
    check("flush_status", stat_w[1], 4'd0);
    cycle(1); cycle(1);

    // CMPS with NZCV=0110, then a non-S instruction
    set_id(1, 4'd0, 4'd1, 4'd2, 1, 0, 0, 1, 0); cycle(1);
    st_bits = 4'b0110; nop(); cycle(1);
    check("cmps_status", stat_w[1], 4'b0110);
    check("cmps_cin", 4'(cin_w[1]), 4'd1);
    set_id(1, 4'd3, 4'd1, 4'd2, 1, 1, 0, 0, 0); st_bits = 4'b1001; cycle(1);
    nop(); cycle(1);
    check("nos_status", stat_w[0], 4'b0110);
    check("nos_cin", 4'(cin_w[0]), 4'd1);
    cycle(1); cycle(1);

    // Load-use with the memory side busy for three cycles
    set_id(1, 4'd4, 4'd0, 4'd0, 0, 1, 1, 0, 0); cycle(1);
    set_id(1, 4'd5, 4'd4, 4'd0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1'b1; #1;
      check("busy_freeze", 4'(frz_w[1]), 4'd1);
      check("busy_nostall", 4'(stl_w[1]), 4'd0);
      cycle(1);
    end
    mem_busy = 1'b0; #1;
    check("release_stall", 4'(stl_w[1]), 4'd1);
    cycle(1);
    check("release_once", 4'(stl_w[1]), 4'd0);
    nop(); cycle(1); cycle(1); cycle(1);

    // Reset during a memory wait
    set_id(1, 4'd2, 4'd0, 4'd0, 0, 1, 0, 1, 0); st_bits = 4'b1010; cycle(1);
    mem_busy = 1'b1; cycle(1);
    rst = 1'b1; cycle(1);
    rst = 1'b0; mem_busy = 1'b0; nop(); #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mrst_freeze[%0d]", k), 4'(frz_w[k]), 4'd0);
      check($sformatf("mrst_stall[%0d]", k), 4'(stl_w[k]), 4'd0);
      check($sformatf("mrst_flush[%0d]", k), 4'(fls_w[k]), 4'd0);
      check($sformatf("mrst_sel1[%0d]", k), 4'(sel1_w[k]), 4'd0);
      check($sformatf("mrst_status[%0d]", k), stat_w[k], 4'd0);
      check($sformatf("mrst_cin[%0d]", k), 4'(cin_w[k]), 4'd0);
    end
    cycle(1);

    // Randomized traffic; ID holds its instruction while stalled or frozen
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      st_bits  = 4'($urandom_range(0, 15));
      if (!(last_stall1 || last_busy)) begin
        set_id($urandom_range(0, 9) != 0,
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
        if (!id_wb_en) id_mem_read = 1'b0;
      end
      mem_busy = ($urandom_range(0, 7) == 0);
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
